deal_sequencer: RTL and testbench



---
 rtl/deal_pkg.sv | 17 +
 rtl/dealer_draw_rule.sv | 17 +
 rtl/deal_sequencer.sv | 87 ++++++++
 tb/tb_deal_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/deal_pkg.sv
// deal_pkg: shared state encoding, rule constants and card-value helper
// for the Baccarat deal sequencer.
package deal_pkg;

    typedef enum logic [3:0] {
        S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_BANK, S_D3, S_SCORE, S_DONE
    } state_t;

    localparam int NATURAL_MIN_DEF     = 8;
    localparam int PLAYER_DRAW_MAX_DEF = 5;
    localparam int DEALER_DRAW_MAX     = 5;

    function automatic logic [3:0] card_value(input logic [3:0] raw);
        return raw >= 4'd10 ? 4'd0 : raw;
    endfunction

endpackage

// File: rtl/dealer_draw_rule.sv
// dealer_draw_rule: dealer third-card table, indexed by the dealer's two-card
// score and the value of the player's third card.
module dealer_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] v,
    output logic       draw
);

    always_comb
        draw = dscore <= 4'd2 ? 1'b1 :
               dscore == 4'd3 ? v != 4'd8 :
               dscore == 4'd4 ? (v >= 4'd2 && v <= 4'd7) :
               dscore == 4'd5 ? (v >= 4'd4 && v <= 4'd7) :
               dscore == 4'd6 ? (v == 4'd6 || v == 4'd7) :
               1'b0;

endmodule

// File: rtl/deal_sequencer.sv
// deal_sequencer: Moore FSM sequencing one Baccarat round: card loads in
// dealing order, third-card decisions and latched winner lights.
module deal_sequencer
    import deal_pkg::*;
#(
    parameter int NATURAL_MIN     = NATURAL_MIN_DEF,
    parameter int PLAYER_DRAW_MAX = PLAYER_DRAW_MAX_DEF
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       round_done
);

    localparam logic [3:0] NAT  = 4'(NATURAL_MIN);
    localparam logic [3:0] PMAX = 4'(PLAYER_DRAW_MAX);
    localparam logic [3:0] DMAX = 4'(DEALER_DRAW_MAX);

    state_t state;
    logic   natural;
    logic   bank_draw;

    // Out-of-range scores (>9) never count as naturals.
    assign natural = (pscore >= NAT && pscore <= 4'd9) || (dscore >= NAT && dscore <= 4'd9);

    dealer_draw_rule u_rule (
        .dscore(dscore),
        .v     (card_value(pcard3)),
        .draw  (bank_draw)
    );

    // Gating with resetb keeps every load low while reset is held.
    always_comb begin
        load_pcard1 = resetb && state == S_P1;
        load_dcard1 = resetb && state == S_D1;
        load_pcard2 = resetb && state == S_P2;
        load_dcard2 = resetb && state == S_D2;
        load_pcard3 = resetb && state == S_P3;
        load_dcard3 = resetb && state == S_D3;
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state            <= S_P1;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            round_done       <= 1'b0;
        end else begin
            case (state)
                S_P1:    state <= S_D1;
                S_D1:    state <= S_P2;
                S_P2:    state <= S_D2;
                S_D2:    state <= S_EVAL;
                S_EVAL:  state <= natural        ? S_SCORE :
                                  pscore <= PMAX ? S_P3 :
                                  dscore <= DMAX ? S_D3 : S_SCORE;
                S_P3:    state <= S_BANK;
                S_BANK:  state <= bank_draw ? S_D3 : S_SCORE;
                S_D3:    state <= S_SCORE;
                S_SCORE: begin
                    state            <= S_DONE;
                    player_win_light <= pscore >= dscore;
                    dealer_win_light <= dscore >= pscore;
                    round_done       <= 1'b1;
                end
                S_DONE:  state <= S_DONE;
                default: begin
                    state            <= S_P1;
                    player_win_light <= 1'b0;
                    dealer_win_light <= 1'b0;
                    round_done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deal_sequencer.sv
// tb_deal_sequencer: scenario and randomized checks of deal_sequencer against
// a Baccarat-rule reference model, plus an exhaustive dealer-table sweep.
module tb_deal_sequencer;

    logic       slow_clock = 1'b0;
    logic       resetb = 1'b0;
    logic [3:0] pscore = 4'd0;
    logic [3:0] dscore = 4'd0;
    logic [3:0] pcard3 = 4'd1;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, round_done;
    logic [3:0] rule_d = 4'd0;
    logic [3:0] rule_v = 4'd0;
    logic       rule_draw;
    logic [5:0] lv;
    int         checks = 0;
    int         failures = 0;

    deal_sequencer dut (
        .slow_clock      (slow_clock),
        .resetb          (resetb),
        .pscore          (pscore),
        .dscore          (dscore),
        .pcard3          (pcard3),
        .load_pcard1     (load_pcard1),
        .load_pcard2     (load_pcard2),
        .load_pcard3     (load_pcard3),
        .load_dcard1     (load_dcard1),
        .load_dcard2     (load_dcard2),
        .load_dcard3     (load_dcard3),
        .player_win_light(player_win_light),
        .dealer_win_light(dealer_win_light),
        .round_done      (round_done)
    );

    dealer_draw_rule u_rule (
        .dscore(rule_d),
        .v     (rule_v),
        .draw  (rule_draw)
    );

    always #5 slow_clock = ~slow_clock;

    assign lv = {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3};

    function automatic int cval(input int raw);
        return raw >= 10 ? 0 : raw;
    endfunction

    function automatic bit bank_rule(input int d, input int v);
        case (d)
            0, 1, 2: return 1'b1;
            3:       return v != 8;
            4:       return v inside {[2:7]};
            5:       return v inside {[4:7]};
            6:       return v inside {[6:7]};
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick;
        @(posedge slow_clock);
        @(negedge slow_clock);
    endtask

    task automatic do_reset;
        resetb = 1'b0;
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    task automatic play_round(input string tag, input int p4, input int d4, input int raw3,
                              input int pf, input int df, output int np3, output int nd3);
        logic [5:0] exp_q[$];
        bit         nat, pd, dd, ep, ed;
        nat = p4 >= 8 || d4 >= 8;
        pd  = !nat && p4 <= 5;
        dd  = nat ? 1'b0 : pd ? bank_rule(d4, cval(raw3)) : d4 <= 5;
        exp_q = '{6'b100000, 6'b000100, 6'b010000, 6'b000010, 6'b000000};
        if (pd) begin
            exp_q.push_back(6'b001000);
            exp_q.push_back(6'b000000);
        end
        if (dd) exp_q.push_back(6'b000001);
        exp_q.push_back(6'b000000);
        ep = pf >= df;
        ed = df >= pf;
        np3 = 0;
        nd3 = 0;
        do_reset;
        pscore = 4'(p4);
        dscore = 4'(d4);
        pcard3 = 4'(raw3);
        foreach (exp_q[i]) begin
            if (i == exp_q.size() - 1) begin
                pscore = 4'(pf);
                dscore = 4'(df);
            end
            #1;
            checks++;
            if (lv !== exp_q[i] || round_done !== 1'b0) begin
                failures++;
                $display("FAIL %s step%0d loads=%b done=%b expected loads=%b done=0",
                         tag, i, lv, round_done, exp_q[i]);
            end
            np3 += int'(load_pcard3);
            nd3 += int'(load_dcard3);
            tick;
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (lv !== 6'b0 || round_done !== 1'b1 || player_win_light !== ep || dealer_win_light !== ed) begin
                failures++;
                $display("FAIL %s done%0d loads=%b done=%b lights=%b%b expected loads=000000 done=1 lights=%b%b",
                         tag, k, lv, round_done, player_win_light, dealer_win_light, ep, ed);
            end
            tick;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({lv, player_win_light, dealer_win_light, round_done} !== 9'b0) begin
            failures++;
            $display("FAIL reset outputs=%b expected 0", {lv, player_win_light, dealer_win_light, round_done});
        end
        @(negedge slow_clock);
    endtask

    task automatic test_rule_table;
        for (int d = 0; d < 10; d++)
            for (int v = 0; v < 10; v++) begin
                rule_d = 4'(d);
                rule_v = 4'(v);
                #1;
                checks++;
                if (rule_draw !== bank_rule(d, v)) begin
                    failures++;
                    $display("FAIL rule d=%0d v=%0d draw=%b expected %b", d, v, rule_draw, bank_rule(d, v));
                end
            end
    endtask

    task automatic test_natural;
        int np3, nd3;
        play_round("natural", 8, 3, 4, 8, 3, np3, nd3);
        checks++;
        if (np3 != 0 || nd3 != 0) begin
            failures++;
            $display("FAIL natural third loads p3=%0d d3=%0d expected 0 0", np3, nd3);
        end
    endtask

    task automatic test_player_stands;
        int np3, nd3;
        play_round("stand", 7, 4, 9, 7, 9, np3, nd3);
        checks++;
        if (np3 != 0 || nd3 != 1) begin
            failures++;
            $display("FAIL stand third loads p3=%0d d3=%0d expected 0 1", np3, nd3);
        end
    endtask

    task automatic test_table_edge;
        int np3, nd3;
        play_round("d3_v8", 2, 3, 8, 0, 3, np3, nd3);
        checks++;
        if (np3 != 1 || nd3 != 0) begin
            failures++;
            $display("FAIL d3_v8 third loads p3=%0d d3=%0d expected 1 0", np3, nd3);
        end
        play_round("d3_v0", 2, 3, 12, 2, 6, np3, nd3);
        checks++;
        if (np3 != 1 || nd3 != 1) begin
            failures++;
            $display("FAIL d3_v0 third loads p3=%0d d3=%0d expected 1 1", np3, nd3);
        end
    endtask

    task automatic test_dealer6;
        int np3, nd3;
        play_round("d6_v5", 3, 6, 5, 8, 6, np3, nd3);
        checks++;
        if (nd3 != 0) begin
            failures++;
            $display("FAIL d6_v5 d3=%0d expected 0", nd3);
        end
        play_round("d6_v6", 3, 6, 6, 9, 1, np3, nd3);
        checks++;
        if (nd3 != 1) begin
            failures++;
            $display("FAIL d6_v6 d3=%0d expected 1", nd3);
        end
    endtask

    task automatic test_tie;
        int np3, nd3;
        play_round("tie", 5, 5, 3, 5, 5, np3, nd3);
        checks++;
        if (player_win_light !== 1'b1 || dealer_win_light !== 1'b1) begin
            failures++;
            $display("FAIL tie lights=%b%b expected 11", player_win_light, dealer_win_light);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        pscore = 4'd2;
        dscore = 4'd3;
        pcard3 = 4'd4;
        repeat (5) tick;
        #1;
        checks++;
        if (lv !== 6'b001000) begin
            failures++;
            $display("FAIL mid_p3 loads=%b expected 001000", lv);
        end
        resetb = 1'b0;
        #1;
        checks++;
        if ({lv, player_win_light, dealer_win_light, round_done} !== 9'b0) begin
            failures++;
            $display("FAIL mid_reset outputs=%b expected 0", {lv, player_win_light, dealer_win_light, round_done});
        end
        @(negedge slow_clock);
        resetb = 1'b1;
        #1;
        checks++;
        if (lv !== 6'b100000 || player_win_light !== 1'b0 || dealer_win_light !== 1'b0 || round_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_restart loads=%b lights=%b%b done=%b expected 100000 00 0",
                     lv, player_win_light, dealer_win_light, round_done);
        end
        tick;
        #1;
        checks++;
        if (lv !== 6'b000100) begin
            failures++;
            $display("FAIL mid_d1 loads=%b expected 000100", lv);
        end
        tick;
    endtask

    task automatic test_random;
        int np3, nd3;
        for (int r = 0; r < 40; r++)
            play_round($sformatf("rand%0d", r), int'($urandom_range(9)), int'($urandom_range(9)),
                       int'($urandom_range(13, 1)), int'($urandom_range(9)), int'($urandom_range(9)),
                       np3, nd3);
    endtask

    initial begin
        test_reset;
        test_rule_table;
        test_natural;
        test_player_stands;
        test_table_edge;
        test_dealer6;
        test_tie;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
